// File: rtl/fir_filter_param.sv
// Parametrised pipelined direct-form FIR filter with sample-valid handshake,
// run-time writable coefficients, round/shift output formatting, optional
// saturation and a sticky overflow flag. Latency: accept edge + 3 edges.
module fir_filter_param #(
  parameter int DATA_W    = 16,
  parameter int COEF_W    = 16,
  parameter int NTAPS     = 9,
  parameter int OUT_W     = 16,
  parameter int OUT_SHIFT = 18,
  parameter int SAT_EN    = 1
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       in_valid,
  input  logic signed [DATA_W-1:0]   in_data,
  input  logic                       coef_we,
  input  logic [$clog2(NTAPS)-1:0]   coef_addr,
  input  logic signed [COEF_W-1:0]   coef_data,
  input  logic                       ovf_clr,
  output logic                       out_valid,
  output logic signed [OUT_W-1:0]    out_data,
  output logic                       ovf
);

  localparam int P_W   = DATA_W + COEF_W;
  localparam int ACC_W = P_W + $clog2(NTAPS);
  localparam int AW    = $clog2(NTAPS);
  // One guard bit so adding the rounding constant can never wrap.
  localparam int R_W   = ACC_W + 1;

  localparam logic signed [R_W-1:0] RND  = R_W'(1) << (OUT_SHIFT - 1);
  localparam logic signed [R_W-1:0] MAXV = (R_W'(1) << (OUT_W - 1)) - R_W'(1);
  localparam logic signed [R_W-1:0] MINV = ~MAXV;

  // Round half toward +inf, then arithmetic shift down to output scale.
  function automatic logic signed [R_W-1:0] round_shift(input logic signed [ACC_W-1:0] a);
    logic signed [R_W-1:0] t;
    t = R_W'(a) + RND;
    return t >>> OUT_SHIFT;
  endfunction

  function automatic logic out_of_range(input logic signed [R_W-1:0] r);
    return (r > MAXV) || (r < MINV);
  endfunction

  // Clamp to the output range when saturation is enabled, else drop MSBs.
  function automatic logic signed [OUT_W-1:0] saturate(input logic signed [R_W-1:0] r);
    if (SAT_EN != 0) begin
      if (r > MAXV) return MAXV[OUT_W-1:0];
      if (r < MINV) return MINV[OUT_W-1:0];
    end
    return r[OUT_W-1:0];
  endfunction

  logic signed [DATA_W-1:0] r_x_p0    [NTAPS];
  logic                     r_vld_p0;
  logic signed [COEF_W-1:0] r_coef    [NTAPS];
  logic signed [P_W-1:0]    r_prod_p1 [NTAPS];
  logic                     r_vld_p1;
  logic signed [ACC_W-1:0]  w_acc_sum;
  logic signed [ACC_W-1:0]  r_acc_p2;
  logic                     r_vld_p2;
  logic signed [R_W-1:0]    w_rnd;
  logic signed [OUT_W-1:0]  r_out_p3;
  logic                     r_vld_p3;
  logic                     r_ovf;

  // Stage p0: delay line shifts only on accepted samples.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_vld_p0 <= 1'b0;
      for (int k = 0; k < NTAPS; k++) r_x_p0[k] <= '0;
    end else begin
      r_vld_p0 <= in_valid;
      if (in_valid) begin
        r_x_p0[0] <= in_data;
        for (int k = 1; k < NTAPS; k++) r_x_p0[k] <= r_x_p0[k-1];
      end
    end
  end

  // Coefficient bank; addresses at or beyond NTAPS match no tap and are dropped.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int k = 0; k < NTAPS; k++) r_coef[k] <= '0;
    end else if (coef_we) begin
      for (int k = 0; k < NTAPS; k++)
        if (coef_addr == AW'(k)) r_coef[k] <= coef_data;
    end
  end

  // Stage p1: full-precision tap products.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_vld_p1 <= 1'b0;
      for (int k = 0; k < NTAPS; k++) r_prod_p1[k] <= '0;
    end else begin
      r_vld_p1 <= r_vld_p0;
      for (int k = 0; k < NTAPS; k++)
        r_prod_p1[k] <= P_W'(r_x_p0[k]) * P_W'(r_coef[k]);
    end
  end

  // Sum of all products, sized so it cannot overflow.
  always_comb begin
    w_acc_sum = '0;
    for (int k = 0; k < NTAPS; k++) w_acc_sum = w_acc_sum + ACC_W'(r_prod_p1[k]);
  end

  // Stage p2: registered accumulator.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_vld_p2 <= 1'b0;
      r_acc_p2 <= '0;
    end else begin
      r_vld_p2 <= r_vld_p1;
      r_acc_p2 <= w_acc_sum;
    end
  end

  // Rounded, shifted accumulator ahead of range handling.
  always_comb begin
    w_rnd = round_shift(r_acc_p2);
  end

  // Stage p3: formatted output, held between valid samples; sticky overflow
  // where a new overflow wins over a simultaneous clear.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_vld_p3 <= 1'b0;
      r_out_p3 <= '0;
      r_ovf    <= 1'b0;
    end else begin
      r_vld_p3 <= r_vld_p2;
      if (r_vld_p2) r_out_p3 <= saturate(w_rnd);
      if (r_vld_p2 && out_of_range(w_rnd)) r_ovf <= 1'b1;
      else if (ovf_clr)                    r_ovf <= 1'b0;
    end
  end

  assign out_valid = r_vld_p3;
  assign out_data  = r_out_p3;
  assign ovf       = r_ovf;

endmodule

// File: tb/tb_fir_filter_param.sv
// Self-checking bench for fir_filter_param (default parameters): table-driven
// stimulus feeding a scoreboard queue, plus hand-written corner sequences.
module tb_fir_filter_param;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic [15:0] in_data = '0;
  logic        coef_we = 1'b0;
  logic [3:0]  coef_addr = '0;
  logic [15:0] coef_data = '0;
  logic        ovf_clr = 1'b0;
  logic        out_valid;
  logic [15:0] out_data;
  logic        ovf;

  fir_filter_param dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .coef_we   (coef_we),
    .coef_addr (coef_addr),
    .coef_data (coef_data),
    .ovf_clr   (ovf_clr),
    .out_valid (out_valid),
    .out_data  (out_data),
    .ovf       (ovf)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] din;
    logic [15:0] exp;
  } vec_t;

  typedef struct {
    logic [15:0] data;
    bit          chk;
    bit          ovf;
    int          cyc;
  } exp_t;

  vec_t imp_tbl [10];
  vec_t rnd_tbl [4];
  exp_t sb [$];
  exp_t mon_e;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // A sample presented at cycle N is accepted on the next edge, so its
  // output becomes visible at the negedge where cyc == N+4.
  always @(negedge clk) begin
    if (out_valid) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_valid got out_valid=1 data=%h want no output", out_data);
      end else begin
        mon_e = sb.pop_front();
        if (mon_e.chk) begin
          checks++;
          if (out_data !== mon_e.data) begin
            errors++;
            $display("FAIL data got %h want %h", out_data, mon_e.data);
          end
        end
        checks++;
        if (ovf !== mon_e.ovf) begin
          errors++;
          $display("FAIL ovf_at_output got %b want %b", ovf, mon_e.ovf);
        end
        checks++;
        if (cyc - mon_e.cyc != 4) begin
          errors++;
          $display("FAIL latency got %0d want 4", cyc - mon_e.cyc);
        end
      end
    end
  end

  task automatic cycle(input logic v, input logic [15:0] d, input logic we,
                       input logic [3:0] a, input logic [15:0] cd, input logic clr,
                       input logic [15:0] e, input bit c, input bit eo);
    @(negedge clk);
    in_valid  = v;
    in_data   = d;
    coef_we   = we;
    coef_addr = a;
    coef_data = cd;
    ovf_clr   = clr;
    if (v) sb.push_back('{data: e, chk: c, ovf: eo, cyc: cyc});
  endtask

  task automatic send(input logic [15:0] d, input logic [15:0] e, input bit c, input bit eo);
    cycle(1'b1, d, 1'b0, 4'd0, 16'h0, 1'b0, e, c, eo);
  endtask

  task automatic idle();
    cycle(1'b0, 16'h0, 1'b0, 4'd0, 16'h0, 1'b0, 16'h0, 1'b0, 1'b0);
  endtask

  task automatic wcoef(input logic [3:0] a, input logic [15:0] cd);
    cycle(1'b0, 16'h0, 1'b1, a, cd, 1'b0, 16'h0, 1'b0, 1'b0);
  endtask

  task automatic clr_pulse();
    cycle(1'b0, 16'h0, 1'b0, 4'd0, 16'h0, 1'b1, 16'h0, 1'b0, 1'b0);
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h", name, act, exp);
    end
  endtask

  task automatic drain();
    for (int i = 0; i < 20 && sb.size() != 0; i++) begin
      @(negedge clk);
      #1;
    end
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL drain_timeout got %0d pending want 0", sb.size());
      sb.delete();
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n    = 1'b0;
    in_valid = 1'b0;
    coef_we  = 1'b0;
    ovf_clr  = 1'b0;
    sb.delete();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    imp_tbl[0] = '{16'h4000, 16'd1};
    for (int i = 1; i < 10; i++) imp_tbl[i] = '{16'h0000, 16'((i + 1) % 10)};
    rnd_tbl[0] = '{16'h4000, 16'h0001};
    rnd_tbl[1] = '{16'hC000, 16'h0000};
    rnd_tbl[2] = '{16'h6000, 16'h0001};
    rnd_tbl[3] = '{16'hA000, 16'hFFFF};

    // Reset state
    do_reset();
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_data", 32'(out_data), 32'd0);
    check("rst_ovf", 32'(ovf), 32'd0);

    // Impulse, continuous valid
    for (int k = 0; k < 9; k++) wcoef(4'(k), 16'(16 * (k + 1)));
    for (int i = 0; i < 10; i++) send(imp_tbl[i].din, imp_tbl[i].exp, 1'b1, 1'b0);
    idle();
    drain();

    // Impulse, gapped valid
    for (int i = 0; i < 10; i++) begin
      send(imp_tbl[i].din, imp_tbl[i].exp, 1'b1, 1'b0);
      idle();
    end
    drain();

    // Rounding with a single tap
    wcoef(4'd0, 16'd8);
    for (int k = 1; k < 9; k++) wcoef(4'(k), 16'h0);
    for (int i = 0; i < 4; i++) send(rnd_tbl[i].din, rnd_tbl[i].exp, 1'b1, 1'b0);
    idle();
    drain();

    // Live coefficient update, write coinciding with a sample
    wcoef(4'd0, 16'd16);
    for (int i = 0; i < 3; i++) send(16'h4000, 16'd1, 1'b1, 1'b0);
    cycle(1'b1, 16'h4000, 1'b1, 4'd0, 16'd32, 1'b0, 16'd2, 1'b1, 1'b0);
    for (int i = 0; i < 2; i++) send(16'h4000, 16'd2, 1'b1, 1'b0);
    wcoef(4'd9, 16'h7FFF);
    wcoef(4'd15, 16'h7FFF);
    for (int i = 0; i < 2; i++) send(16'h4000, 16'd2, 1'b1, 1'b0);
    idle();
    drain();

    // Saturation and sticky overflow
    do_reset();
    for (int k = 0; k < 9; k++) wcoef(4'(k), 16'h7FFF);
    for (int j = 1; j <= 7; j++) send(16'h7FFF, 16'h0, 1'b0, 1'b0);
    send(16'h7FFF, 16'h7FFE, 1'b1, 1'b0);
    send(16'h7FFF, 16'h7FFF, 1'b1, 1'b1);
    for (int j = 1; j <= 8; j++) send(16'h8000, 16'h0, 1'b0, 1'b1);
    send(16'h8000, 16'h8000, 1'b1, 1'b1);
    idle();
    drain();
    idle();
    idle();
    check("hold_out_data", 32'(out_data), 32'h8000);
    check("ovf_sticky", 32'(ovf), 32'd1);
    clr_pulse();
    idle();
    check("ovf_cleared", 32'(ovf), 32'd0);

    // Overflow set beats a simultaneous clear
    send(16'h8000, 16'h8000, 1'b1, 1'b1);
    idle();
    idle();
    clr_pulse();
    idle();
    check("ovf_set_priority", 32'(ovf), 32'd1);
    drain();
    clr_pulse();
    idle();
    check("ovf_cleared_again", 32'(ovf), 32'd0);
    send(16'h8000, 16'h8000, 1'b1, 1'b1);
    idle();
    drain();

    // Reset with three samples in flight
    for (int i = 0; i < 3; i++) send(16'h7FFF, 16'h0, 1'b0, 1'b1);
    do_reset();
    check("midrst_out_valid", 32'(out_valid), 32'd0);
    check("midrst_out_data", 32'(out_data), 32'd0);
    check("midrst_ovf", 32'(ovf), 32'd0);
    for (int i = 0; i < 10; i++) send(imp_tbl[i].din, 16'h0, 1'b1, 1'b0);
    idle();
    drain();
    repeat (5) idle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fir_filter_param.md
Name: fir_filter_param

Overview:
- Parametrised, pipelined direct-form FIR filter. Successor to the fixed 9-tap, free-running filter.
- Adds a sample-valid handshake, coefficients writable at run time, configurable round/shift and saturation, and a sticky overflow flag.
- Sits between the sample source (ADC or DMA front end) and downstream DSP. Instantiated once per channel.

Parameters:
- DATA_W, 16, input sample width (signed two's complement)
- COEF_W, 16, coefficient width (signed)
- NTAPS, 9, number of taps (2..64)
- OUT_W, 16, output sample width (signed)
- OUT_SHIFT, 18, right shift applied to the accumulator before output (must be ≥1)
- SAT_EN, 1, 1 = saturate output to OUT_W; 0 = wrap (truncate MSBs)

Ports:
- clk  in  1  clock; all logic on rising edge
- rst_n  in  1  synchronous active-low reset
- in_valid  in  1  in_data is a new sample this cycle
- in_data  in  DATA_W  signed input sample
- coef_we  in  1  coefficient write strobe
- coef_addr  in  clog2(NTAPS)  tap index; 0 multiplies the newest sample
- coef_data  in  COEF_W  signed coefficient value
- ovf_clr  in  1  clears the sticky ovf flag
- out_valid  out  1  out_data valid this cycle
- out_data  out  OUT_W  signed filtered sample
- ovf  out  1  sticky: set when a saturation or wrap event occurred

Behaviour:
- Internal widths: product P_W = DATA_W+COEF_W; accumulator ACC_W = P_W + clog2(NTAPS). Full-precision signed arithmetic with no internal overflow.
- Reset (rst_n=0 at a rising edge):
  - Delay line and coefficients cleared to 0; all pipeline registers cleared to 0.
  - out_valid=0, out_data=0, ovf=0.
  - Reset mid-stream discards every in-flight sample. No out_valid is produced for samples accepted before reset.
- Delay line x[0..NTAPS-1]:
  - Shifts only on an edge where in_valid=1: x[0]<=in_data, x[k]<=x[k-1].
  - Holds when in_valid=0. No backpressure; every in_valid sample is accepted.
- Pipeline and latency:
  - Edge E0: sample accepted. Edge E1: products p[k]=x[k]*c[k] registered. Edge E2: accumulator = sum of p[k], registered as an adder tree. Edge E3: rounded/saturated result registered.
  - out_valid=1 for exactly one cycle following E3, i.e. latency 3 cycles.
  - A valid bit travels alongside each stage. Back-to-back in_valid yields back-to-back out_valid.
- Coefficient write:
  - c[coef_addr]<=coef_data on an edge with coef_we=1.
  - The new value is used by the product stage from the next edge on. Samples already past the product stage are unaffected.
  - coef_addr ≥ NTAPS is ignored.
  - Write and in_valid in the same cycle are both honoured.
- Output formatting:
  - r = (acc + 2^(OUT_SHIFT-1)) >>> OUT_SHIFT, an arithmetic shift (round half toward +inf).
  - SAT_EN=1: if r > 2^(OUT_W-1)-1, output max positive; if r < -2^(OUT_W-1), output min negative.
  - SAT_EN=0: out_data = r[OUT_W-1:0].
- Overflow flag:
  - ovf is set on the E3 edge of any valid sample whose r is out of OUT_W range, in either SAT_EN mode.
  - Cleared by ovf_clr or reset. Set has priority over ovf_clr in the same cycle.
- out_data holds its last value while out_valid=0.

Test Plan:
- Impulse:
  - Stimulus: c[k]=16*(k+1); one sample 0x4000 followed by zeros, in_valid continuous.
  - Response: out_data = 1,2,...,9 then 0, the first output 3 cycles after the impulse is accepted.
- Gapped input:
  - Stimulus: same impulse, in_valid alternating 1/0.
  - Response: identical output sequence, one out_valid per accepted sample, with no shift of the delay line during idle cycles.
- Saturation:
  - Stimulus: all c=0x7FFF; 9 samples of 0x7FFF.
  - Response: final out_data=0x7FFF, ovf=1.
  - Then 9 samples of 0x8000: out_data=0x8000, ovf remains 1.
  - Then ovf_clr pulse: ovf=0.
- Rounding:
  - Stimulus: c[0]=8, other taps 0.
  - Response: input 0x4000 gives out 1; input 0xC000 gives out 0 (ties round toward +inf).
- Live coefficient update:
  - Stimulus: DC input 0x4000 with c[0]=16; write c[0]=32 mid-stream.
  - Response: output steps 1 to 2 exactly on the sample whose product is computed after the write edge.
- Reset mid-stream:
  - Stimulus: assert rst_n=0 for 1 cycle while 3 samples are in flight.
  - Response: no out_valid for those samples; out_data=0, ovf=0; coefficients read back as 0 (impulse gives all-zero output).
